// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling FSM, one-deep holding register.
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  // Two cycles of synchroniser/IDLE latency are absorbed into the start-bit half period.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 frame_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      frame_good <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_good <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          par_bad <= 1'b0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= STOP;
            if (rx_s != (^shift)) begin
              parity_err <= 1'b1;
              par_bad    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              frame_good <= !par_bad;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Holding register: a good frame loads only if empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver pushes expected events, a monitor pops and compares.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int EXP_LAT = 2 + CPB / 2 + (DB + 1 + PAR) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  typedef enum int {EV_DATA, EV_FERR, EV_PERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DB-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  model_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [DB-1:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [DB-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none at %0t", k, d, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == EV_DATA && k == EV_DATA) check("rx_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: a load is visible when rx_valid is high and the previous cycle left the register empty or drained it.
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DB-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && (!prev_valid || prev_ready)) observe(EV_DATA, rx_data);
      if (prev_valid && !prev_ready && rx_valid) check("hold_stable", 32'(rx_data), 32'(prev_data));
      if (frame_err)  observe(EV_FERR, '0);
      if (parity_err) observe(EV_PERR, '0);
      if (overrun)    observe(EV_OVR, '0);
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: decides the outcome of a frame from its content and the consumer state.
  task automatic frame(input logic [DB-1:0] d, input bit par_ok, input bit stop_bit);
    logic pbit;
    if (PAR == 1 && !par_ok) expect_ev(EV_PERR, '0);
    if (!stop_bit) begin
      expect_ev(EV_FERR, '0);
    end else if (PAR == 0 || par_ok) begin
      if (!model_full || rx_ready) begin
        expect_ev(EV_DATA, d);
        if (!rx_ready) model_full = 1'b1;
      end else begin
        expect_ev(EV_OVR, '0);
      end
    end
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    pbit = (^d) ^ !par_ok;
    if (PAR == 1) drive_bit(pbit);
    drive_bit(stop_bit);
  endtask

  task automatic set_ready(input logic r);
    rx_ready = r;
    if (r) model_full = 1'b0;
    idle(4);
  endtask

  initial begin
    int lat;
    int n_lo;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_parity_err", 32'(parity_err), 0);
    check("reset_overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(2 * CPB);

    // Latency of a single frame and one-cycle valid with ready held high
    lat = -1;
    fork
      frame(8'h69, 1'b1, 1'b1);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(posedge clk);
          #1;
          if (rx_valid) begin
            lat = k;
            break;
          end
        end
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(rx_valid), 0);
      end
    join
    check("latency", 32'(lat), 32'(EXP_LAT));
    idle(CPB);

    // Back-to-back frames into a stalled consumer
    set_ready(1'b0);
    frame(8'h69, 1'b1, 1'b1);
    frame(8'hA5, 1'b1, 1'b1);
    idle(2 * CPB);
    check("stall_valid", 32'(rx_valid), 1);
    check("stall_data", 32'(rx_data), 32'h69);
    set_ready(1'b1);
    check("drained_valid", 32'(rx_valid), 0);
    check("drained_data_hold", 32'(rx_data), 32'h69);

    // Short low glitch is rejected silently
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(2 * CPB);
    check("glitch_valid", 32'(rx_valid), 0);

    // Bad stop bit followed by a long break, then a clean frame
    frame(8'h3C, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    frame(8'h55, 1'b1, 1'b1);
    idle(CPB);

    // Reset during data bit 4 of 0xFF abandons the frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midframe_reset_valid", 32'(rx_valid), 0);
    idle(CPB);
    frame(8'h0F, 1'b1, 1'b1);
    idle(CPB);

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b0, 1'b1);
    idle(CPB);
    frame(8'h07, 1'b1, 1'b1);
    idle(CPB);
`endif

    // Randomised frames, stop errors, glitches and consumer stalls
    for (int n = 0; n < 40; n++) begin
      set_ready(logic'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 7) == 0) begin
        rx = 1'b0;
        n_lo = $urandom_range(1, CPB / 2 - 2);
        repeat (n_lo) @(posedge clk);
        #1;
        idle(CPB);
      end
      frame(DB'($urandom), (PAR == 0) || ($urandom_range(0, 7) != 0), $urandom_range(0, 9) != 0);
      if (frame_err || dut.rx_s == 1'b0) begin
        rx = 1'b0;
      end
      if (rx == 1'b0) begin
        repeat ($urandom_range(1, 3) * CPB) @(posedge clk);
        #1;
        idle(2 * CPB);
      end else begin
        idle($urandom_range(0, CPB));
      end
    end

    for (int k = 0; k < 20 * CPB && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    idle(4);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
